// File: rtl/pwm_ui_pkg.sv
// Shared types for the PWM user-input stage: FSM state and step direction.
package pwm_ui_pkg;

  // Button-service state of the duty controller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no button being serviced
    HOLD = 2'd1,  // initial step taken, waiting for the first repeat
    RPT  = 2'd2,  // auto-repeating
    LOCK = 2'd3   // conflicting input seen, waiting for both buttons released
  } state_t;

  // Direction of the button currently being serviced.
  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button/duty bundle between the input source and the duty controller.
interface pwm_duty_ctrl_if #(
  parameter int DUTY_W = 4
);
  logic              btn_up;
  logic              btn_dn;
  logic [DUTY_W-1:0] duty;
  logic              duty_chg;
  logic              at_max;
  logic              at_min;

  // Drives the buttons and observes the duty word.
  modport master (
    output btn_up, btn_dn,
    input  duty, duty_chg, at_max, at_min
  );

  // The duty controller itself.
  modport slave (
    input  btn_up, btn_dn,
    output duty, duty_chg, at_max, at_min
  );
endinterface

// File: rtl/up_cnt_pmtr.sv
// Free-running up counter with synchronous clear and count enable.
module up_cnt_pmtr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Clear wins over count; wraps silently at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Turns debounced up/down buttons into a saturating duty word with
// press-to-step, hold-to-repeat behaviour and a one-cycle change strobe.
module pwm_duty_ctrl
  import pwm_ui_pkg::*;
#(
  parameter int DUTY_W     = 4,
  parameter int DUTY_MAX   = 8,
  parameter int STEP       = 1,
  parameter int RESET_DUTY = 0,
  parameter int CNT_W      = 25,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  pwm_duty_ctrl_if.slave  bus
);

  // Timer values at which the next edge is a repeat step.
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  // Step arithmetic is one bit wider so duty+STEP cannot wrap before clamping.
  localparam logic [DUTY_W:0] MAX_X  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(STEP);

  state_t            state, state_nxt;
  dir_t              dir, dir_nxt;
  logic              up_q, dn_q;
  logic              rise_up, rise_dn;
  logic              held, opp;
  logic              step_en;
  dir_t              step_dir;
  logic              tmr_clr;
  logic [CNT_W-1:0]  tmr;
  logic [DUTY_W-1:0] duty;
  logic [DUTY_W-1:0] duty_step;
  logic              duty_chg;
  logic [DUTY_W:0]   duty_x, sum_up, val_up, val_dn, val_step;

  assign rise_up = bus.btn_up & ~up_q;
  assign rise_dn = bus.btn_dn & ~dn_q;

  // Button being serviced and the one opposing it.
  assign held = (dir == DIR_UP) ? bus.btn_up : bus.btn_dn;
  assign opp  = (dir == DIR_UP) ? bus.btn_dn : bus.btn_up;

  // Repeat timer: held at zero while idle or locked, restarted on every step.
  up_cnt_pmtr #(
    .WIDTH(CNT_W)
  ) u_rpt_tmr (
    .clk(clk),
    .rst(rst),
    .en (1'b1),
    .clr(tmr_clr),
    .cnt(tmr)
  );

  // Next-state, step request and timer clear for the button-service FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt = state;
    dir_nxt   = dir;
    step_en   = 1'b0;
    step_dir  = dir;
    tmr_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (rise_up && !bus.btn_dn) begin
          step_en   = 1'b1;
          step_dir  = DIR_UP;
          dir_nxt   = DIR_UP;
          state_nxt = HOLD;
        end else if (rise_dn && !bus.btn_up) begin
          step_en   = 1'b1;
          step_dir  = DIR_DN;
          dir_nxt   = DIR_DN;
          state_nxt = HOLD;
        end else if (rise_up || rise_dn) begin
          state_nxt = LOCK;
        end
      end
      HOLD: begin
        if (!held) begin
          state_nxt = IDLE;
        end else if (opp) begin
          state_nxt = LOCK;
        end else if (tmr == DLY_LAST) begin
          step_en   = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = RPT;
        end
      end
      RPT: begin
        if (!held) begin
          state_nxt = IDLE;
        end else if (opp) begin
          state_nxt = LOCK;
        end else if (tmr == PER_LAST) begin
          step_en = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      LOCK: begin
        tmr_clr = 1'b1;
        if (!bus.btn_up && !bus.btn_dn) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating step adder for both directions.
  always_comb begin
    duty_x   = {1'b0, duty};
    sum_up   = duty_x + STEP_X;
    val_up   = (sum_up > MAX_X) ? MAX_X : sum_up;
    val_dn   = (duty_x < STEP_X) ? '0 : duty_x - STEP_X;
    val_step = (step_dir == DIR_UP) ? val_up : val_dn;
    duty_step = DUTY_W'(val_step);
  end

  // State, edge-detect history, duty word and change strobe.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      dir      <= DIR_UP;
      up_q     <= 1'b1;  // a button held through reset must be released first
      dn_q     <= 1'b1;
      duty     <= DUTY_W'(RESET_DUTY);
      duty_chg <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      up_q     <= bus.btn_up;
      dn_q     <= bus.btn_dn;
      duty_chg <= 1'b0;
      if (step_en) begin
        duty     <= duty_step;
        duty_chg <= (duty_step != duty);
      end
    end
  end

  assign bus.duty     = duty;
  assign bus.duty_chg = duty_chg;
  assign bus.at_max   = (duty == DUTY_W'(DUTY_MAX));
  assign bus.at_min   = (duty == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl: directed scenarios with literal
// expectations plus randomized button activity against a behavioural model.
module tb_pwm_duty_ctrl;

  localparam int DUTY_W   = 4;
  localparam int DUTY_MAX = 8;
  localparam int STEP     = 1;
  localparam int DLY      = 8;
  localparam int PER      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  pwm_duty_ctrl_if #(.DUTY_W(DUTY_W)) bus ();

  pwm_duty_ctrl #(
    .DUTY_W    (DUTY_W),
    .DUTY_MAX  (DUTY_MAX),
    .STEP      (STEP),
    .RESET_DUTY(0),
    .CNT_W     (25),
    .REPEAT_DLY(DLY),
    .REPEAT_PER(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, +1 servicing up, -1 servicing down, 2 locked.
  // age: edges elapsed since the press that started the current hold.
  int m_duty = 0;
  bit m_chg  = 1'b0;
  bit p_up   = 1'b1;
  bit p_dn   = 1'b1;
  int mode   = 0;
  int age    = 0;

  // Model updates on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin : model
    int step, nd;
    bit ru, rd, hold_btn, opp_btn;
    if (rst) begin
      m_duty = 0; m_chg = 1'b0; p_up = 1'b1; p_dn = 1'b1; mode = 0; age = 0;
    end else begin
      step = 0;
      ru = bus.btn_up && !p_up;
      rd = bus.btn_dn && !p_dn;
      if (mode == 0) begin
        if (ru && !bus.btn_dn)      begin step = 1;  mode = 1;  age = 0; end
        else if (rd && !bus.btn_up) begin step = -1; mode = -1; age = 0; end
        else if (ru || rd)          mode = 2;
      end else if (mode == 2) begin
        if (!bus.btn_up && !bus.btn_dn) mode = 0;
      end else begin
        hold_btn = (mode == 1) ? bus.btn_up : bus.btn_dn;
        opp_btn  = (mode == 1) ? bus.btn_dn : bus.btn_up;
        if (!hold_btn)     mode = 0;
        else if (opp_btn)  mode = 2;
        else begin
          age++;
          if (age == DLY || (age > DLY && (age - DLY) % PER == 0)) step = mode;
        end
      end
      if (step != 0) begin
        nd = m_duty + step * STEP;
        if (nd > DUTY_MAX) nd = DUTY_MAX;
        if (nd < 0) nd = 0;
        m_chg  = (nd != m_duty);
        m_duty = nd;
      end else begin
        m_chg = 1'b0;
      end
      p_up = bus.btn_up;
      p_dn = bus.btn_dn;
    end
  end

  // Every cycle out of reset, all outputs must agree with the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("duty",     bus.duty,     m_duty);
      check("duty_chg", bus.duty_chg, m_chg);
      check("at_max",   bus.at_max,   (m_duty == DUTY_MAX));
      check("at_min",   bus.at_min,   (m_duty == 0));
    end
  end

  // Counts change strobes for the directed scenarios.
  always @(posedge clk) begin
    #1;
    if (!rst && bus.duty_chg === 1'b1) pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input bit u, input bit d);
    bus.btn_up = u;
    bus.btn_dn = d;
  endtask

  // Hold the given buttons for n edges, then release and settle.
  task automatic press(input bit u, input bit d, input int n);
    set_btn(u, d);
    cyc(n);
    set_btn(1'b0, 1'b0);
    cyc(2);
  endtask

  // Assert reset mid-cycle and check the outputs react without a clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_duty"},     bus.duty,     0);
    check({tag, "_duty_chg"}, bus.duty_chg, 0);
    check({tag, "_at_min"},   bus.at_min,   1);
    #1 rst = 1'b0;
  endtask

  initial begin
    set_btn(1'b0, 1'b0);
    #3 rst = 1'b1;
    cyc(2);
    #1 rst = 1'b0;
    cyc(1);
    check("rst_duty",   bus.duty,     0);
    check("rst_chg",    bus.duty_chg, 0);
    check("rst_at_min", bus.at_min,   1);
    check("rst_at_max", bus.at_max,   0);

    // Single press: one step, one strobe, no repeat.
    pulses = 0;
    press(1'b1, 1'b0, 3);
    cyc(1);
    check("single_duty",   bus.duty, 1);
    check("single_pulses", pulses,   1);
    press(1'b0, 1'b1, 1);
    check("back_to_zero", bus.duty, 0);

    // Hold up 30 edges: steps at 0,8,12,16,20,24,28.
    pulses = 0;
    press(1'b1, 1'b0, 30);
    check("hold30_duty",   bus.duty, 7);
    check("hold30_pulses", pulses,   7);

    // Saturate at the top: one real change, silent repeats afterwards.
    pulses = 0;
    press(1'b1, 1'b0, 20);
    check("sat_up_duty",   bus.duty,   DUTY_MAX);
    check("sat_up_pulses", pulses,     1);
    check("sat_up_at_max", bus.at_max, 1);

    // Hold down 45 edges from the top: ends at 0 after 8 real changes.
    pulses = 0;
    press(1'b0, 1'b1, 45);
    check("sat_dn_duty",   bus.duty,   0);
    check("sat_dn_pulses", pulses,     8);
    check("sat_dn_at_min", bus.at_min, 1);

    // Down at zero: no change, no strobe.
    pulses = 0;
    press(1'b0, 1'b1, 3);
    check("dn_at_zero_duty",   bus.duty, 0);
    check("dn_at_zero_pulses", pulses,   0);

    repeat (3) press(1'b1, 1'b0, 1);
    check("climb_duty", bus.duty, 3);

    // Simultaneous press locks out both buttons until both are released.
    pulses = 0;
    set_btn(1'b1, 1'b1);
    cyc(3);
    check("simul_duty", bus.duty, 3);
    set_btn(1'b0, 1'b1);
    cyc(1);
    set_btn(1'b1, 1'b1);
    cyc(10);
    check("relock_duty",   bus.duty, 3);
    check("relock_pulses", pulses,   0);
    set_btn(1'b0, 1'b0);
    cyc(2);
    press(1'b0, 1'b1, 2);
    check("unlock_dn_duty",   bus.duty, 2);
    check("unlock_dn_pulses", pulses,   1);

    // Reset while a button is held: ignored until released and pressed again.
    repeat (2) press(1'b1, 1'b0, 1);
    set_btn(1'b1, 1'b0);
    cyc(3);
    check("held_duty", bus.duty, 5);
    async_reset("held_rst");
    cyc(12);
    check("held_after_rst", bus.duty, 0);
    set_btn(1'b0, 1'b0);
    cyc(2);
    press(1'b1, 1'b0, 1);
    check("repress_duty", bus.duty, 1);

    // Randomized button activity with occasional mid-cycle resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) bus.btn_up = ~bus.btn_up;
      if ($urandom_range(0, 19) == 0) bus.btn_dn = ~bus.btn_dn;
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    set_btn(1'b0, 1'b0);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
